// File: rtl/user_pkg.sv
// Shared types for the OBI copy manager: manager-port request/response structs,
// the word stride and the copy FSM state encoding.
package user_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;
  localparam int unsigned WordStride   = 4;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } copy_state_e;

endpackage

// File: rtl/obi_copy_mgr.sv
// OBI manager copy engine: moves len_i words from src to dst, one read then one
// write per word, with a single transaction outstanding at any time.
module obi_copy_mgr
  import user_pkg::*;
#(
  parameter int unsigned AddrWidth = ObiAddrWidth,
  parameter int unsigned DataWidth = ObiDataWidth,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output mgr_obi_req_t         obi_req_o,
  input  mgr_obi_rsp_t         obi_rsp_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [AddrWidth-1:0] Stride = AddrWidth'(WordStride);

  copy_state_e          state_q, state_d;
  logic [AddrWidth-1:0] src_ptr_q, src_ptr_d;
  logic [AddrWidth-1:0] dst_ptr_q, dst_ptr_d;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Word alignment is forced, so the two low address bits are deliberately dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_ptr_d   = {src_addr_i[AddrWidth-1:2], 2'b00};
          dst_ptr_d   = {dst_addr_i[AddrWidth-1:2], 2'b00};
          remaining_d = len_i;
          err_d       = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (obi_rsp_i.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            data_d  = obi_rsp_i.r.rdata;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (obi_rsp_i.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            src_ptr_d   = src_ptr_q + Stride;
            dst_ptr_d   = dst_ptr_q + Stride;
            remaining_d = remaining_q - LenWidth'(1);
            if (remaining_q == LenWidth'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields come straight from state and registers, so they hold stable until gnt.
  always_comb begin
    obi_req_o = '0;
    if (state_q == RD_REQ) begin
      obi_req_o.req    = 1'b1;
      obi_req_o.a.addr = src_ptr_q;
      obi_req_o.a.be   = '1;
    end else if (state_q == WR_REQ) begin
      obi_req_o.req     = 1'b1;
      obi_req_o.a.we    = 1'b1;
      obi_req_o.a.addr  = dst_ptr_q;
      obi_req_o.a.be    = '1;
      obi_req_o.a.wdata = data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_obi_copy_mgr.sv
// Bench for obi_copy_mgr: an OBI memory subordinate with random stalls and
// response delays, a transaction-level copy model feeding a scoreboard queue.
module tb_obi_copy_mgr;
  import user_pkg::*;

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  mgr_obi_req_t obi_req_o;
  mgr_obi_rsp_t obi_rsp_i = '0;
  logic         start_i    = 1'b0;
  logic [31:0]  src_addr_i = '0;
  logic [31:0]  dst_addr_i = '0;
  logic [15:0]  len_i      = '0;
  logic         busy_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  obi_copy_mgr #(.AddrWidth(32), .DataWidth(32), .LenWidth(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .obi_req_o  (obi_req_o),
    .obi_rsp_i  (obi_rsp_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          exp_err_g;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Subordinate configuration (written by the stimulus, read by the subordinate)
  int stall_fixed   = 0;   // >=0: fixed gnt-low cycles per request, <0: random
  int stall_max     = 0;
  int dly_max       = 0;
  int err_read_idx  = -1;
  int stray_req     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequential word-by-word copy, read then write, stopping on the failing read.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int err_idx);
    logic [31:0] ra, wa, d;
    txn_t t;
    exp_err_g = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      ra = (src & ~32'h3) + 32'(4 * i);
      wa = (dst & ~32'h3) + 32'(4 * i);
      t.addr = ra; t.we = 1'b0; t.data = '0;
      exp_q.push_back(t);
      if (i == err_idx) begin
        exp_err_g = 1'b1;
        return;
      end
      d = ref_mem.exists(ra) ? ref_mem[ra] : 32'h0;
      ref_mem[wa] = d;
      t.addr = wa; t.we = 1'b1; t.data = d;
      exp_q.push_back(t);
    end
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    logic [31:0] a, d;
    for (int i = 0; i < n; i++) begin
      a = (base & ~32'h3) + 32'(4 * i);
      d = $urandom;
      bus_mem[a] = d;
      ref_mem[a] = d;
    end
  endtask

  // OBI subordinate: drives gnt/rvalid on the falling edge, owns its own bookkeeping.
  bit          rsp_pending = 0;
  int          rsp_delay   = 0;
  logic [31:0] rsp_data    = '0;
  bit          rsp_err     = 0;
  int          wait_cnt    = 0;
  int          stall_target = 0;
  int          read_idx    = 0;
  int          stray_done  = 0;

  always @(negedge clk_i) begin
    obi_rsp_i.gnt    = 1'b0;
    obi_rsp_i.rvalid = 1'b0;
    obi_rsp_i.r      = '0;
    if (!rst_ni) begin
      rsp_pending = 0;
    end else if (rsp_pending) begin
      if (rsp_delay == 0) begin
        obi_rsp_i.rvalid  = 1'b1;
        obi_rsp_i.r.rdata = rsp_data;
        obi_rsp_i.r.err   = rsp_err;
        rsp_pending = 0;
      end else begin
        rsp_delay--;
      end
    end else if (stray_req != stray_done) begin
      obi_rsp_i.rvalid  = 1'b1;
      obi_rsp_i.r.err   = 1'b1;
      obi_rsp_i.r.rdata = 32'hBAD0BAD0;
      stray_done++;
    end
    if (!busy_o) begin
      read_idx     = 0;
      wait_cnt     = 0;
      stall_target = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(stall_max, 0));
    end
    if (rst_ni && obi_req_o.req) begin
      if (wait_cnt >= stall_target) begin
        obi_rsp_i.gnt = 1'b1;
        wait_cnt      = 0;
        stall_target  = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(stall_max, 0));
        rsp_pending   = 1;
        rsp_delay     = int'($urandom_range(dly_max, 0));
        rsp_err       = 0;
        rsp_data      = '0;
        if (obi_req_o.a.we) begin
          bus_mem[obi_req_o.a.addr] = obi_req_o.a.wdata;
        end else begin
          rsp_data = bus_mem.exists(obi_req_o.a.addr) ? bus_mem[obi_req_o.a.addr] : 32'h0;
          rsp_err  = (read_idx == err_read_idx);
          read_idx++;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: stability while stalled, scoreboard compare on every granted request.
  bit           held = 0;
  mgr_obi_req_t held_req;
  txn_t         mon_e;

  always @(negedge clk_i) begin
    #1;
    if (!rst_ni) begin
      held = 0;
    end else begin
      check("busy_done_exclusive", 32'(busy_o & done_o), 32'h0);
      if (obi_req_o.req) begin
        if (held) begin
          check("stall_addr_stable",  obi_req_o.a.addr,      held_req.a.addr);
          check("stall_we_stable",    32'(obi_req_o.a.we),   32'(held_req.a.we));
          check("stall_wdata_stable", obi_req_o.a.wdata,     held_req.a.wdata);
        end
        if (obi_rsp_i.gnt) begin
          held = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: got addr 0x%08h we %0b, expected no request",
                     obi_req_o.a.addr, obi_req_o.a.we);
          end else begin
            mon_e = exp_q.pop_front();
            check("txn_addr",  obi_req_o.a.addr,     mon_e.addr);
            check("txn_we",    32'(obi_req_o.a.we),  32'(mon_e.we));
            check("txn_be",    32'(obi_req_o.a.be),  32'hF);
            check("txn_aid",   32'(obi_req_o.a.aid), 32'h0);
            check("txn_wdata", obi_req_o.a.wdata,    mon_e.we ? mon_e.data : 32'h0);
          end
        end else begin
          held     = 1;
          held_req = obi_req_o;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int err_idx);
    @(negedge clk_i);
    err_read_idx = err_idx;
    model_copy(src, dst, len, err_idx);
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    #2;
    while (!(!busy_o && done_o) && cycles < budget) begin
      @(negedge clk_i);
      #2;
      cycles++;
    end
    check("done_within_budget", 32'(done_o && !busy_o), 32'h1);
    check("err_flag",           32'(err_o),             32'(exp_err_g));
    check("queue_drained",      32'(exp_q.size()),      32'h0);
  endtask

  int cyc;
  logic [31:0] rs, rd;

  initial begin
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_req",   32'(obi_req_o.req),    32'h0);
    check("rst_addr",  obi_req_o.a.addr,      32'h0);
    check("rst_we",    32'(obi_req_o.a.we),   32'h0);
    check("rst_be",    32'(obi_req_o.a.be),   32'h0);
    check("rst_wdata", obi_req_o.a.wdata,     32'h0);
    check("rst_aid",   32'(obi_req_o.a.aid),  32'h0);
    check("rst_busy",  32'(busy_o),           32'h0);
    check("rst_done",  32'(done_o),           32'h0);
    check("rst_err",   32'(err_o),            32'h0);
    rst_ni = 1'b1;

    // Single word, immediate gnt and rvalid: 4 cycles per word
    bus_mem[32'h1000] = 32'hDEADBEEF;
    ref_mem[32'h1000] = 32'hDEADBEEF;
    start_copy(32'h1000, 32'h2000, 16'd1, -1);
    wait_done(40, cyc);
    check("single_latency", 32'(cyc), 32'd4);
    check("single_mem", bus_mem[32'h2000], 32'hDEADBEEF);

    // Zero length: done next cycle, never busy, no request
    start_copy(32'h1000, 32'h5000, 16'd0, -1);
    #2;
    check("zero_len_done", 32'(done_o), 32'h1);
    check("zero_len_busy", 32'(busy_o), 32'h0);
    repeat (3) begin
      @(negedge clk_i);
      #2;
      check("zero_len_no_req", 32'(obi_req_o.req), 32'h0);
    end
    wait_done(5, cyc);

    // gnt stall of 5 cycles on every request
    stall_fixed = 5;
    fill(32'h3000, 2);
    start_copy(32'h3000, 32'h4000, 16'd2, -1);
    wait_done(200, cyc);
    check("stall_mem0", bus_mem[32'h4000], ref_mem[32'h3000]);
    check("stall_mem1", bus_mem[32'h4004], ref_mem[32'h3004]);
    stall_fixed = 0;

    // Error on the second read: one write only, then abort
    fill(32'h6000, 3);
    start_copy(32'h6000, 32'h7000, 16'd3, 1);
    wait_done(100, cyc);
    check("rderr_done", 32'(done_o), 32'h1);

    // Start while busy is ignored
    stall_fixed = -1; stall_max = 2; dly_max = 2;
    fill(32'h8000, 4);
    start_copy(32'h8002, 32'h9001, 16'd4, -1);
    repeat (3) @(negedge clk_i);
    dst_addr_i = 32'hA000;
    len_i      = 16'd1;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    wait_done(300, cyc);
    check("busy_start_mem3", bus_mem[32'h900C], ref_mem[32'h800C]);

    // Stray rvalid while idle must not touch the flags
    stray_req++;
    repeat (3) @(negedge clk_i);
    #2;
    check("stray_err",  32'(err_o),  32'h0);
    check("stray_done", 32'(done_o), 32'h1);

    // Address wrap with error on the read at 0x0, then a restart clears both flags
    fill(32'hFFFFFFFC, 1);
    start_copy(32'hFFFFFFFC, 32'hB000, 16'd2, 1);
    wait_done(100, cyc);
    fill(32'hC000, 1);
    start_copy(32'hC000, 32'hD000, 16'd1, -1);
    #2;
    check("restart_clears_err",  32'(err_o),  32'h0);
    check("restart_clears_done", 32'(done_o), 32'h0);
    wait_done(100, cyc);

    // Maximum length is legal; stop it early with a read error
    start_copy(32'h10000, 32'h20000, 16'hFFFF, 3);
    wait_done(300, cyc);

    // Randomized copies
    for (int it = 0; it < 10; it++) begin
      int n, e;
      rs = $urandom;
      rd = $urandom;
      n  = int'($urandom_range(6, 1));
      e  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      fill(rs, n);
      start_copy(rs, rd, 16'(n), e);
      wait_done(400, cyc);
    end

    // Reset mid-copy aborts without completion
    stall_fixed = 3;
    fill(32'hE000, 4);
    start_copy(32'hE000, 32'hF000, 16'd4, -1);
    repeat (4) @(negedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("midrst_req",  32'(obi_req_o.req), 32'h0);
    check("midrst_busy", 32'(busy_o),        32'h0);
    check("midrst_done", 32'(done_o),        32'h0);
    check("midrst_err",  32'(err_o),         32'h0);
    exp_q.delete();
    @(negedge clk_i);
    #3;
    rst_ni = 1'b1;
    stall_fixed = 0;
    fill(32'h11000, 1);
    start_copy(32'h11000, 32'h12000, 16'd1, -1);
    wait_done(40, cyc);
    check("post_reset_mem", bus_mem[32'h12000], ref_mem[32'h11000]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation time limit, expected test completion");
    $fatal(1, "timeout");
  end

endmodule
